rca_pipe_addsub: RTL and testbench
==================================

Name: rca_pipe_addsub

Overview:
Parametrised, pipelined ripple-carry adder/subtractor. It is the clocked successor to the fixed-width combinational ripple-carry adder. Operands of WIDTH bits are split into STAGES equal chunks. Each chunk is resolved by a combinational ripple in its own pipeline stage, and the carry is registered between stages. It sits in the arithmetic datapath of the basic-circuits library, uses a valid/ready handshake on both sides, and sustains one result per clock.

Parameters:
WIDTH, 8, operand/result width in bits; must be >= 1.
STAGES, 4, number of pipeline stages (and chunks); must divide WIDTH exactly; STAGES=1 is a single-cycle registered adder.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand beat valid
in_ready  output  1  block accepts a beat this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
ci  input  1  carry-in (add) / borrow-in (sub)
sub  input  1  0: s=a+b+ci; 1: s=a-b-ci
out_valid  output  1  result beat valid
out_ready  input  1  downstream accepts result
s  output  WIDTH  sum/difference
co  output  1  raw carry-out of MSB (sub: 1 = no borrow)
ovf  output  1  two's-complement signed overflow

Behaviour:
- Reset: synchronous, active-high, on clk rising edge.
  - All stage valid bits clear, so out_valid=0.
  - s, co, ovf and every skew/partial-sum register clear to 0.
  - in_ready=0 while rst=1.
- Reset mid-operation: all in-flight beats are discarded. The first beat after rst deasserts is accepted normally, with no residue from before reset.
- Arithmetic: CHUNK = WIDTH/STAGES.
  - Effective operand is b_eff = b ^ {WIDTH{sub}}.
  - Effective carry-in is c0 = ci ^ sub, so sub computes a + ~b + !ci.
  - Stage k (0-based) adds bits [k*CHUNK +: CHUNK] of a and b_eff with the carry registered from stage k-1; stage 0 uses c0.
  - co = carry out of bit WIDTH-1.
  - ovf = carry into MSB XOR carry out of MSB.
- Skew: operand chunks k>0 are delayed k cycles through skew registers so each chunk meets its carry. Completed low chunks are carried forward (deskewed) so that all of s appears in the same cycle.
- Latency: exactly STAGES cycles from the accept edge to out_valid=1 with that beat's result, absent stalls.
- Handshake:
  - A beat is accepted when in_valid && in_ready at the clk edge.
  - A result is consumed when out_valid && out_ready.
  - stall = out_valid && !out_ready.
  - in_ready = !rst && !stall (combinational).
  - While stalled, every pipeline register (data, carry, valid) holds. s/co/ovf stay stable while out_valid=1 and out_ready=0.
- No bubbles are created by the block. Throughput is 1 beat/clk with out_ready held high. A bubble (in_valid=0) propagates as a cleared valid bit; data registers may update but have no meaning.
- Simultaneous accept and consume in the same cycle is legal and required for full throughput.
- Boundaries:
  - Add 0xFF..F + 1 wraps s to 0 with co=1.
  - WIDTH=STAGES gives 1-bit chunks.
  - STAGES=1 has no skew registers.

Decomposition:
- Shared package, rca_pkg:
  - localparam function for CHUNK;
  - an elaboration check that WIDTH % STAGES == 0 (a $error in a generate block).
- One natural sub-module: rca_chunk, a combinational CHUNK-bit ripple of full adders.
  - Inputs: x, y, cin. Outputs: sum, cout, and c_msb_in (carry into its top bit, used for ovf in the last chunk).
  - Instantiated STAGES times in a generate loop.

Test Plan:
1. WIDTH=4, STAGES=1, all 512 combinations of a, b, ci with sub=0, out_ready=1 -> each s/co matches a+b+ci exactly one cycle after accept.
2. WIDTH=8, STAGES=4, add cases, each result 4 cycles after accept:
   - 0x5A+0x3C, ci=0 -> s=0x96, co=0, ovf=1.
   - 0xFF+0x01 -> s=0x00, co=1, ovf=0.
3. WIDTH=8, STAGES=4, subtract cases:
   - 0x10-0x20, ci=0 -> s=0xF0, co=0, ovf=0.
   - 0x80-0x01 -> s=0x7F, co=1, ovf=1.
   - 0x05-0x05, ci=1 -> s=0xFF, co=0.
4. Back-to-back 16 random beats, in_valid=1 and out_ready=1 throughout -> in_ready stays 1, out_valid is continuous from cycle 4, results arrive in order and match the model.
5. Stall: out_ready=0 for 3 cycles while out_valid=1 -> in_ready=0, s/co/ovf are held unchanged, no beat is lost or duplicated after out_ready returns to 1.
6. Reset mid-stream: assert rst for 1 cycle with 3 beats in flight -> next cycle out_valid=0 and s=0. A new beat 0x01+0x01 then yields s=0x02 4 cycles after accept, with no stale output.

Source files
------------

// File: rtl/rca_pkg.sv
// Shared definitions for the pipelined ripple-carry adder/subtractor.
// Provides the chunk-width helper used to size each pipeline slice.
package rca_pkg;

    // Bits resolved per pipeline stage. The top checks that stages divides width.
    function automatic int chunk_w(input int width, input int stages);
        return (stages > 0) ? (width / stages) : width;
    endfunction

endpackage

// File: rtl/rca_chunk.sv
// Combinational W-bit ripple of full adders: one pipeline slice of the adder.
// Ports:
//   x, y      : chunk operands (y already inverted for subtract)
//   cin       : carry into bit 0
//   sum       : chunk sum
//   cout      : carry out of bit W-1
//   c_msb_in  : carry into bit W-1 (the top chunk uses it for signed overflow)
module rca_chunk #(
    parameter int W = 2
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         c_msb_in
);

    logic [W:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < W; i++) begin
            sum[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1]   = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
    end

    assign cout     = c[W];
    assign c_msb_in = c[W-1];

endmodule

// File: rtl/rca_pipe_addsub.sv
// Pipelined ripple-carry adder/subtractor with valid/ready on both sides.
// The operand is cut into STAGES chunks; chunk k ripples in stage k using the
// carry registered from chunk k-1. Upper operand chunks are skewed forward and
// finished low chunks are delayed so the whole result appears in one cycle.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand beat handshake
//   a, b, ci, sub       : operands, carry/borrow in, 0=add 1=subtract
//   out_valid/out_ready : result beat handshake
//   s, co, ovf          : result, raw carry-out of MSB, signed overflow
module rca_pipe_addsub
    import rca_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf
);

    localparam int CHUNK = chunk_w(WIDTH, STAGES);

    if ((WIDTH < 1) || (STAGES < 1) || ((WIDTH % STAGES) != 0)) begin : g_bad_param
        $error("rca_pipe_addsub: WIDTH (%0d) must be a positive multiple of STAGES (%0d)",
               WIDTH, STAGES);
    end

    logic             stall;
    logic             advance;
    logic             accept;
    logic [WIDTH-1:0] b_eff;
    wire  [STAGES-1:0] cin_w;   // carry into each chunk
    wire  [WIDTH-1:0]  s_w;

    // Stage valid bits; index k is the beat that has passed k registers.
    logic [STAGES:1] vld_pipe_q, vld_pipe_d;

    assign out_valid = vld_pipe_q[STAGES];
    assign stall     = out_valid && !out_ready;
    assign advance   = !stall;
    assign in_ready  = !rst && !stall;
    assign accept    = in_valid && in_ready;

    // Subtract is a + ~b + !ci.
    assign b_eff    = b ^ {WIDTH{sub}};
    assign cin_w[0] = ci ^ sub;
    assign s        = s_w;

    always_comb begin
        vld_pipe_d = vld_pipe_q;
        if (advance) begin
            vld_pipe_d[1] = accept;
            for (int i = 2; i <= STAGES; i++) vld_pipe_d[i] = vld_pipe_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) vld_pipe_q <= '0;
        else     vld_pipe_q <= vld_pipe_d;
    end

    for (genvar j = 0; j < STAGES; j++) begin : g_stg
        localparam int DS = STAGES - j;   // registers from this chunk to the output

        logic [CHUNK-1:0] x_w, y_w, sum_w;
        logic             cout_w, cmsb_w;

        // Operand skew: chunk j waits j cycles so it meets its incoming carry.
        if (j == 0) begin : g_noskew
            assign x_w = a[CHUNK-1:0];
            assign y_w = b_eff[CHUNK-1:0];
        end else begin : g_skew
            logic [j-1:0][CHUNK-1:0] xs_q, xs_d, ys_q, ys_d;

            always_comb begin
                xs_d = xs_q;
                ys_d = ys_q;
                if (advance) begin
                    xs_d[0] = a[j*CHUNK +: CHUNK];
                    ys_d[0] = b_eff[j*CHUNK +: CHUNK];
                    for (int i = 1; i < j; i++) begin
                        xs_d[i] = xs_q[i-1];
                        ys_d[i] = ys_q[i-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    xs_q <= '0;
                    ys_q <= '0;
                end else begin
                    xs_q <= xs_d;
                    ys_q <= ys_d;
                end
            end

            assign x_w = xs_q[j-1];
            assign y_w = ys_q[j-1];
        end

        rca_chunk #(.W(CHUNK)) u_chunk (
            .x        (x_w),
            .y        (y_w),
            .cin      (cin_w[j]),
            .sum      (sum_w),
            .cout     (cout_w),
            .c_msb_in (cmsb_w)
        );

        // Deskew: the finished chunk rides DS registers so all chunks line up.
        logic [DS-1:0][CHUNK-1:0] ss_q, ss_d;

        always_comb begin
            ss_d = ss_q;
            if (advance) begin
                ss_d[0] = sum_w;
                for (int i = 1; i < DS; i++) ss_d[i] = ss_q[i-1];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) ss_q <= '0;
            else     ss_q <= ss_d;
        end

        assign s_w[j*CHUNK +: CHUNK] = ss_q[DS-1];

        if (j < STAGES - 1) begin : g_cy
            logic cy_q, cy_d;

            always_comb begin
                cy_d = cy_q;
                if (advance) cy_d = cout_w;
            end

            always_ff @(posedge clk) begin
                if (rst) cy_q <= 1'b0;
                else     cy_q <= cy_d;
            end

            assign cin_w[j+1] = cy_q;
        end else begin : g_msb
            logic co_q, co_d, ovf_q, ovf_d;

            always_comb begin
                co_d  = co_q;
                ovf_d = ovf_q;
                if (advance) begin
                    co_d  = cout_w;
                    ovf_d = cout_w ^ cmsb_w;   // carry into MSB != carry out of MSB
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    co_q  <= 1'b0;
                    ovf_q <= 1'b0;
                end else begin
                    co_q  <= co_d;
                    ovf_q <= ovf_d;
                end
            end

            assign co  = co_q;
            assign ovf = ovf_q;
        end
    end

endmodule

// File: tb/tb_rca_pipe_addsub.sv
// Self-checking bench: 8-bit/4-stage instance driven through a scoreboard of
// arithmetic expectations, plus a 4-bit/1-stage instance swept exhaustively.
module tb_rca_pipe_addsub;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, ci, sub, out_valid, out_ready, co, ovf;
    logic [7:0] a, b, s;

    logic       in_valid1, in_ready1, ci1, sub1, out_valid1, out_ready1, co1, ovf1;
    logic [3:0] a1, b1, s1;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         n_in    = 0;
    int         n_out   = 0;
    logic [9:0] sb_q[$];
    logic       stall_prev = 1'b0;
    logic [9:0] held;

    always #5 clk = ~clk;

    rca_pipe_addsub #(.WIDTH(8), .STAGES(S)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ci(ci), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .s(s), .co(co), .ovf(ovf)
    );

    rca_pipe_addsub #(.WIDTH(4), .STAGES(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .ci(ci1), .sub(sub1), .out_valid(out_valid1),
        .out_ready(out_ready1), .s(s1), .co(co1), .ovf(ovf1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // {ovf, co, s} from plain integer arithmetic.
    function automatic logic [9:0] model8(input logic [7:0] x, y, input logic c, m);
        int ux, uy, sx, sy, r, sr;
        logic cy, v;
        logic [7:0] res;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (m) begin
            r  = ux - uy - int'(c);
            sr = sx - sy - int'(c);
            cy = (r >= 0);          // no borrow
        end else begin
            r  = ux + uy + int'(c);
            sr = sx + sy + int'(c);
            cy = (r > 255);
        end
        res = r[7:0];
        v   = (sr > 127) || (sr < -128);
        return {v, cy, res};
    endfunction

    function automatic logic [5:0] model4(input logic [3:0] x, y, input logic c);
        int r, sr;
        logic [3:0] res;
        r   = int'(x) + int'(y) + int'(c);
        sr  = int'($signed(x)) + int'($signed(y)) + int'(c);
        res = r[3:0];
        return {(sr > 7) || (sr < -8), r > 15, res};
    endfunction

    // One clock of the 8-bit instance: drive at negedge, then check what the
    // coming posedge will accept/consume.
    task automatic tick(input logic irst, input logic iv, input logic [7:0] ia, ib,
                        input logic ici, isub, iordy);
        logic [9:0] e;
        @(negedge clk);
        rst = irst; in_valid = iv; a = ia; b = ib; ci = ici; sub = isub; out_ready = iordy;
        #1;
        if (rst) begin
            chk("rst_in_ready", in_ready, 0);
            sb_q.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && out_valid) chk("stall_hold", {ovf, co, s}, held);
            chk("in_ready", in_ready, !(out_valid && !out_ready));
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) chk("extra_beat", out_valid, 0);
                else begin
                    e = sb_q.pop_front();
                    chk("result", {ovf, co, s}, e);
                    n_out++;
                end
            end
            if (in_valid && in_ready) begin
                sb_q.push_back(model8(a, b, ci, sub));
                n_in++;
            end
            stall_prev = out_valid && !out_ready;
            held       = {ovf, co, s};
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 8'h00, 8'h00, 0, 0, 1);
    endtask

    task automatic rnd_beat(input logic ordy);
        tick(0, 1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), ordy);
    endtask

    // Single beat into an empty pipe: latency and spec constants.
    task automatic directed(input string tag, input logic [7:0] ia, ib, input logic ici, isub,
                            input logic [7:0] es, input logic eco, eovf);
        int lat;
        tick(0, 1, ia, ib, ici, isub, 1);
        lat = 0;
        do begin
            tick(0, 0, 8'h00, 8'h00, 0, 0, 1);
            lat++;
        end while (!out_valid && lat < 20);
        chk({tag, "_latency"}, lat, S);
        chk({tag, "_s"}, s, es);
        chk({tag, "_co"}, co, eco);
        chk({tag, "_ovf"}, ovf, eovf);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        int         in0, out0;
        logic [8:0] t;
        logic [5:0] exp1;

        in_valid1 = 0; a1 = 0; b1 = 0; ci1 = 0; sub1 = 0; out_ready1 = 1;
        exp1 = '0;

        // Reset state
        tick(1, 0, 8'h00, 8'h00, 0, 0, 1);
        tick(1, 0, 8'h00, 8'h00, 0, 0, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_s", {ovf, co, s}, 0);
        chk("reset_out_valid1", out_valid1, 0);
        idle(1);

        // 4-bit single-stage instance, every a/b/ci, back to back
        for (int i = 0; i <= 512; i++) begin
            @(negedge clk);
            t = 9'(i);
            in_valid1 = (i < 512);
            {ci1, a1, b1} = t;
            #1;
            if (i > 0)   chk("w4s1_result", {out_valid1, ovf1, co1, s1}, {1'b1, exp1});
            if (i < 512) chk("w4s1_in_ready", in_ready1, 1);
            exp1 = model4(a1, b1, ci1);
        end
        in_valid1 = 0;

        // Directed add / subtract cases
        directed("add_5a_3c",  8'h5A, 8'h3C, 0, 0, 8'h96, 0, 1);
        directed("add_ff_01",  8'hFF, 8'h01, 0, 0, 8'h00, 1, 0);
        directed("sub_10_20",  8'h10, 8'h20, 0, 1, 8'hF0, 0, 0);
        directed("sub_80_01",  8'h80, 8'h01, 0, 1, 8'h7F, 1, 1);
        directed("sub_05_05b", 8'h05, 8'h05, 1, 1, 8'hFF, 0, 0);
        idle(2);

        // 16 beats back to back at full rate
        out0 = n_out;
        for (int i = 0; i < 16 + S; i++) begin
            if (i < 16) rnd_beat(1);
            else        tick(0, 0, 8'h00, 8'h00, 0, 0, 1);
            if (i >= S) chk("b2b_out_valid", out_valid, 1);
        end
        chk("b2b_count", n_out - out0, 16);

        // Stall with a full pipe
        in0 = n_in; out0 = n_out;
        for (int i = 0; i < 6; i++) rnd_beat(1);
        for (int i = 0; i < 3; i++) begin
            rnd_beat(0);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_in_ready", in_ready, 0);
        end
        idle(S + 4);
        chk("stall_conserve", n_out - out0, n_in - in0);
        chk("stall_drained", sb_q.size(), 0);

        // Random valid/ready traffic
        for (int i = 0; i < 300; i++)
            tick(0, 1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0));
        idle(S + 8);
        chk("rand_drained", sb_q.size(), 0);

        // Reset with three beats in flight
        for (int i = 0; i < 3; i++) rnd_beat(1);
        tick(1, 0, 8'h00, 8'h00, 0, 0, 1);
        tick(0, 0, 8'h00, 8'h00, 0, 0, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_s", s, 0);
        directed("post_rst_01_01", 8'h01, 8'h01, 0, 0, 8'h02, 0, 0);
        idle(S + 4);
        chk("final_drained", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
